// File: rtl/dcache_arb_if.sv
// Requester and data-cache signal bundle for dcache_arbiter.
// The slave modport is the arbiter. The master modport is the environment: both requesters plus the cache read-data return.
interface dcache_arb_if;
   logic        a_req;
   logic        a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_done;
   logic [31:0] a_rdata;
   logic        a_err;

   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_done;
   logic [31:0] b_rdata;
   logic        b_err;

   logic [31:0] dc_addr;
   logic [31:0] dc_data_in;
   logic [4:0]  dc_uop;
   logic [31:0] dc_data_out;
   logic        busy;

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output dc_data_out,
      input  a_done, a_rdata, a_err,
      input  b_done, b_rdata, b_err,
      input  dc_addr, dc_data_in, dc_uop, busy
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  dc_data_out,
      output a_done, a_rdata, a_err,
      output b_done, b_rdata, b_err,
      output dc_addr, dc_data_in, dc_uop, busy
   );
endinterface

// File: rtl/dcache_arbiter.sv
// Two-port data-cache access controller.
// It arbitrates between port A (CPU) and port B (debug/DMA) and runs one cache access at a time.
// Each access walks IDLE -> ISSUE -> RESP -> DONE. An out-of-range address goes straight from IDLE to DONE with err set.
// Optional feature: define DCACHE_ARB_STARVE_EN to force a B grant after STARVE_LIMIT consecutive A grants made while B waits.
module dcache_arbiter (
   input  logic        clock,
   input  logic        reset_n,
   dcache_arb_if.slave bus
);
   localparam int unsigned ADDR_BITS = 5;
   localparam int unsigned UOP_W     = 5;
   localparam int unsigned DATA_W    = 32;
   localparam logic [UOP_W-1:0] STR_UOP = 5'b01001;
   localparam logic [UOP_W-1:0] LDR_UOP = 5'b01010;
   localparam logic [UOP_W-1:0] NOP_UOP = 5'b00000;
`ifdef DCACHE_ARB_STARVE_EN
   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned CNT_W        = 3;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                owner_b_q, owner_b_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   dc_addr_q, dc_addr_d;
   logic [DATA_W-1:0]   dc_data_in_q, dc_data_in_d;
   logic [UOP_W-1:0]    dc_uop_q, dc_uop_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                a_done_q, a_done_d;
   logic                b_done_q, b_done_d;
   logic                a_err_q, a_err_d;
   logic                b_err_q, b_err_d;
   logic                busy_q, busy_d;
`ifdef DCACHE_ARB_STARVE_EN
   logic [CNT_W-1:0]    starve_q, starve_d;
`endif

   logic                grant_b_c;
   logic                sel_we_c;
   logic [DATA_W-1:0]   sel_addr_c;
   logic [DATA_W-1:0]   sel_wdata_c;
   logic                in_range_c;

   // Arbitration: A has fixed priority unless B has waited through too many A grants.
   always_comb begin
      grant_b_c = bus.b_req && !bus.a_req;
`ifdef DCACHE_ARB_STARVE_EN
      if (bus.b_req && (starve_q == CNT_W'(STARVE_LIMIT))) begin
         grant_b_c = 1'b1;
      end
`endif
      sel_we_c    = grant_b_c ? bus.b_we    : bus.a_we;
      sel_addr_c  = grant_b_c ? bus.b_addr  : bus.a_addr;
      sel_wdata_c = grant_b_c ? bus.b_wdata : bus.a_wdata;
      in_range_c  = (sel_addr_c[DATA_W-1:ADDR_BITS] == '0);
   end

   // State and output registers; reset leaves the cache micro-op at NOP, so a pending store is dropped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         owner_b_q    <= 1'b0;
         we_q         <= 1'b0;
         dc_addr_q    <= '0;
         dc_data_in_q <= '0;
         dc_uop_q     <= NOP_UOP;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
         a_done_q     <= 1'b0;
         b_done_q     <= 1'b0;
         a_err_q      <= 1'b0;
         b_err_q      <= 1'b0;
         busy_q       <= 1'b0;
`ifdef DCACHE_ARB_STARVE_EN
         starve_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_b_q    <= owner_b_d;
         we_q         <= we_d;
         dc_addr_q    <= dc_addr_d;
         dc_data_in_q <= dc_data_in_d;
         dc_uop_q     <= dc_uop_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
         a_done_q     <= a_done_d;
         b_done_q     <= b_done_d;
         a_err_q      <= a_err_d;
         b_err_q      <= b_err_d;
         busy_q       <= busy_d;
`ifdef DCACHE_ARB_STARVE_EN
         starve_q     <= starve_d;
`endif
      end
   end

   // Next-state and next-output logic; done, err and rdata default low so they pulse for one cycle.
   always_comb begin
      state_d      = state_q;
      owner_b_d    = owner_b_q;
      we_d         = we_q;
      dc_addr_d    = dc_addr_q;
      dc_data_in_d = dc_data_in_q;
      dc_uop_d     = dc_uop_q;
      a_rdata_d    = '0;
      b_rdata_d    = '0;
      a_done_d     = 1'b0;
      b_done_d     = 1'b0;
      a_err_d      = 1'b0;
      b_err_d      = 1'b0;
`ifdef DCACHE_ARB_STARVE_EN
      starve_d     = starve_q;
`endif

      case (state_q)
         S_IDLE: begin
            dc_uop_d     = NOP_UOP;
            dc_addr_d    = '0;
            dc_data_in_d = '0;
            if (bus.a_req || bus.b_req) begin
               owner_b_d = grant_b_c;
               we_d      = sel_we_c;
`ifdef DCACHE_ARB_STARVE_EN
               if (grant_b_c) begin
                  starve_d = '0;
               end else if (bus.b_req) begin
                  starve_d = starve_q + CNT_W'(1);
               end
`endif
               if (in_range_c) begin
                  dc_uop_d     = sel_we_c ? STR_UOP : LDR_UOP;
                  dc_addr_d    = sel_addr_c;
                  dc_data_in_d = sel_we_c ? sel_wdata_c : '0;
                  state_d      = S_ISSUE;
               end else begin
                  a_done_d = !grant_b_c;
                  b_done_d = grant_b_c;
                  a_err_d  = !grant_b_c;
                  b_err_d  = grant_b_c;
                  state_d  = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            dc_uop_d = NOP_UOP;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (owner_b_q) begin
               b_done_d  = 1'b1;
               b_rdata_d = we_q ? '0 : bus.dc_data_out;
            end else begin
               a_done_d  = 1'b1;
               a_rdata_d = we_q ? '0 : bus.dc_data_out;
            end
            dc_addr_d    = '0;
            dc_data_in_d = '0;
            state_d      = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign bus.a_done     = a_done_q;
   assign bus.b_done     = b_done_q;
   assign bus.a_err      = a_err_q;
   assign bus.b_err      = b_err_q;
   assign bus.a_rdata    = a_rdata_q;
   assign bus.b_rdata    = b_rdata_q;
   assign bus.dc_addr    = dc_addr_q;
   assign bus.dc_data_in = dc_data_in_q;
   assign bus.dc_uop     = dc_uop_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dcache_arbiter.sv
// Scoreboard bench for dcache_arbiter.
// It contains a word-array cache model and a queue-based reference of the arbitration and memory rules.
module tb_dcache_arbiter;
   localparam logic [4:0] STR_UOP = 5'b01001;
   localparam logic [4:0] LDR_UOP = 5'b01010;
   localparam logic [4:0] NOP_UOP = 5'b00000;
   localparam int STARVE_LIMIT = 4;
`ifdef DCACHE_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   typedef struct {
      bit          port_b;
      bit          err;
      logic [31:0] rdata;
      int          due;
   } exp_t;

   logic clock;
   logic reset_n;
   dcache_arb_if bus ();

   dcache_arbiter dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int uop_cnt = 0;
   int starve_cnt = 0;
   bit late_drop = 1'b0;
   logic [31:0] cache_mem [32];
   logic [31:0] ref_mem   [32];
   op_t  qa[$];
   op_t  qb[$];
   exp_t exp_q[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Cache model: stores at the falling edge, registered load data after an LDR edge.
   always @(negedge clock) begin
      if (bus.dc_uop == STR_UOP) cache_mem[bus.dc_addr[4:0]] = bus.dc_data_in;
   end
   always @(posedge clock) begin
      if (bus.dc_uop == LDR_UOP) bus.dc_data_out <= cache_mem[bus.dc_addr[4:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse, otherwise checks the outputs are quiet.
   always @(negedge clock) begin
      exp_t e;
      if (!reset_n) begin
         uop_cnt = 0;
      end else begin
         if (bus.dc_uop != NOP_UOP) uop_cnt++;
         if (bus.a_done || bus.b_done) begin
            chk("two_done", 32'(bus.a_done && bus.b_done), 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("done_port", 32'(bus.b_done), 32'(e.port_b));
               chk("done_err", 32'(e.port_b ? bus.b_err : bus.a_err), 32'(e.err));
               chk("done_rdata", e.port_b ? bus.b_rdata : bus.a_rdata, e.rdata);
               chk("done_cycle", 32'(cyc), 32'(e.due));
               chk("uop_cycles", 32'(uop_cnt), e.err ? 32'd0 : 32'd1);
            end
            uop_cnt = 0;
         end else begin
            chk("quiet_outputs", {bus.a_rdata | bus.b_rdata}, 32'd0);
            chk("quiet_err", 32'(bus.a_err | bus.b_err), 32'd0);
         end
      end
   end

   // Drives queued ops from both ports; the reference picks the winner and predicts the response.
   task automatic run_ops();
      op_t  op;
      exp_t e;
      bit   gb;
      bit   got;
      bit   inr;
      while (qa.size() > 0 || qb.size() > 0) begin
         if (qa.size() > 0) begin
            bus.a_req = 1'b1; bus.a_we = qa[0].we; bus.a_addr = qa[0].addr; bus.a_wdata = qa[0].wdata;
         end else bus.a_req = 1'b0;
         if (qb.size() > 0) begin
            bus.b_req = 1'b1; bus.b_we = qb[0].we; bus.b_addr = qb[0].addr; bus.b_wdata = qb[0].wdata;
         end else bus.b_req = 1'b0;
         gb = (qb.size() > 0) && ((qa.size() == 0) || (STARVE_EN && starve_cnt == STARVE_LIMIT));
         if (gb) starve_cnt = 0;
         else if (qb.size() > 0) starve_cnt++;
         op = gb ? qb.pop_front() : qa.pop_front();
         inr = (op.addr < 32);
         e.port_b = gb;
         e.err    = !inr;
         e.rdata  = (!op.we && inr) ? ref_mem[op.addr[4:0]] : 32'd0;
         e.due    = cyc + (inr ? 3 : 1);
         if (op.we && inr) ref_mem[op.addr[4:0]] = op.wdata;
         exp_q.push_back(e);
         got = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (gb ? bus.b_done : bus.a_done) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
         end
         if (late_drop) @(negedge clock);
         if (gb) bus.b_req = 1'b0;
         else bus.a_req = 1'b0;
         @(negedge clock);
      end
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   function automatic op_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      op_t o;
      o.we = we; o.addr = addr; o.wdata = wdata;
      return o;
   endfunction

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 9) < 8) return 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) return 32'($urandom_range(32, 63));
      return $urandom | 32'h8000_0000;
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) begin
         cache_mem[i] = 32'd0;
         ref_mem[i]   = 32'd0;
      end
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
      bus.dc_data_out = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_uop", 32'(bus.dc_uop), 32'(NOP_UOP));
      chk("rst_addr", bus.dc_addr, 32'd0);
      chk("rst_wdata", bus.dc_data_in, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.a_done | bus.b_done), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // B store then load of the same word
      qb.push_back(mk(1'b1, 32'd3, 32'hDEAD_BEEF));
      qb.push_back(mk(1'b0, 32'd3, 32'd0));
      run_ops();

      // Simultaneous requests: A first, then B
      qa.push_back(mk(1'b0, 32'd1, 32'd0));
      qb.push_back(mk(1'b0, 32'd2, 32'd0));
      run_ops();

      // Out-of-range load
      qa.push_back(mk(1'b0, 32'h20, 32'd0));
      run_ops();

      // A keeps requesting while B waits
      for (int i = 0; i < 6; i++) qa.push_back(mk(1'b0, 32'($urandom_range(0, 31)), 32'd0));
      qb.push_back(mk(1'b1, 32'd7, 32'hCAFE_0007));
      run_ops();

      // Reset during the ISSUE cycle of a store must drop the store
      qa.push_back(mk(1'b1, 32'd5, 32'h0000_0055));
      run_ops();
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'd5; bus.a_wdata = 32'h1234;
      @(posedge clock);
      #1;
      chk("issue_uop", 32'(bus.dc_uop), 32'(STR_UOP));
      reset_n = 1'b0;
      #1;
      chk("rst_issue_uop", 32'(bus.dc_uop), 32'(NOP_UOP));
      chk("rst_issue_busy", 32'(bus.busy), 32'd0);
      chk("rst_issue_done", 32'(bus.a_done), 32'd0);
      bus.a_req = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      starve_cnt = 0;
      repeat (2) @(negedge clock);
      qa.push_back(mk(1'b0, 32'd5, 32'd0));
      run_ops();

      // Req held through DONE gives one done and no second access
      late_drop = 1'b1;
      qb.push_back(mk(1'b0, 32'd3, 32'd0));
      run_ops();
      late_drop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("held_req_idle", 32'(bus.busy), 32'd0);
         @(negedge clock);
      end

      // Randomized mixed traffic
      for (int r = 0; r < 40; r++) begin
         int na = $urandom_range(0, 3);
         int nb = $urandom_range(0, 3);
         for (int i = 0; i < na; i++) qa.push_back(mk(1'($urandom_range(0, 1)), rnd_addr(), $urandom));
         for (int i = 0; i < nb; i++) qb.push_back(mk(1'($urandom_range(0, 1)), rnd_addr(), $urandom));
         run_ops();
      end

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
endmodule
